sobel_pixel_source: RTL and testbench
=====================================

SOBEL_PIXEL_SOURCE -- requirements
Module: sobel_pixel_source

Interface
REQ-001 Parameter N, default 450, frame height in rows.
REQ-002 Parameter M, default 600, frame width in columns.
REQ-003 Parameter AW, default 19, address width; SHALL satisfy 2**AW >= N*M.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 wr_en  input  1  host write strobe into the frame buffer.
REQ-007 wr_addr  input  AW  raster address, row*M+col.
REQ-008 wr_data  input  8  pixel byte to store.
REQ-009 start  input  1  one-cycle request to stream one frame.
REQ-010 data_valid  output  1  pixel strobe to the downstream filter.
REQ-011 Dout  output  8  pixel byte, meaningful only while data_valid=1.
REQ-012 sof  output  1  high with the first pixel of a frame.
REQ-013 eol  output  1  high with the last pixel of each row.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse after the last pixel.
REQ-016 wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-017 The block SHALL hold an N*M x 8 frame buffer with one write port and one synchronous read port (1-cycle read latency).
REQ-018 The FSM SHALL have states IDLE, PRIME, STREAM, FIN.
REQ-019 IDLE: a start=1 SHALL move to PRIME, set busy=1 next cycle, clear read address to 0.
REQ-020 PRIME: exactly one cycle; issues read of address 0; goes to STREAM.
REQ-021 STREAM: data_valid=1 every cycle for exactly N*M consecutive cycles, Dout = buffer[k] on the k-th valid cycle, k=0..N*M-1, raster order.
REQ-022 data_valid SHALL never drop inside a frame (the downstream filter resets its store index on any gap).
REQ-023 Latency: start sampled at edge t -> first data_valid at edge t+2.
REQ-024 A column counter 0..M-1 and row counter 0..N-1 SHALL track the output; eol=1 when col=M-1; sof=1 when row=0 and col=0; both qualified by data_valid.
REQ-025 Column wrap M-1 -> 0 SHALL increment row; at row=N-1, col=M-1 the FSM SHALL go to FIN.
REQ-026 FIN: done=1 and busy=0 for one cycle, data_valid=0; then IDLE.
REQ-027 start while busy=1 or in FIN SHALL be ignored (no queueing).
REQ-028 wr_en while busy=0 SHALL write wr_data to wr_addr; wr_addr >= N*M SHALL be dropped with wr_err pulse.
REQ-029 wr_en while busy=1 SHALL be dropped and pulse wr_err next cycle; buffer content streamed is never modified mid-frame.
REQ-030 wr_en in the same cycle as an accepted start SHALL be performed (busy still 0) and be visible in that frame.
REQ-031 Back-to-back frames: start on the FIN cycle is ignored; start on the following IDLE cycle is accepted, giving exactly one idle gap of >=2 cycles between frames.

Reset
REQ-032 rst=1 at any edge SHALL force IDLE, data_valid=0, sof=0, eol=0, busy=0, done=0, wr_err=0, counters=0, Dout=0.
REQ-033 rst mid-frame SHALL terminate the frame immediately with no done pulse; buffer contents are not cleared.
REQ-034 wr_en and start SHALL be ignored while rst=1.

Structure
REQ-035 N, M, AW and the FSM state encoding SHALL live in a shared package sobel_pkg used also by the filter.
REQ-036 The frame buffer SHALL be a sub-module sobel_frame_ram (1W/1R, synchronous read, no reset) so it maps to block RAM.

Verification (bench with N=4, M=5)
REQ-037 Write buffer[a]=a for a=0..19, pulse start at edge 10 -> data_valid edges 12..31, Dout 0..19, sof at 12, eol at 16,21,26,31, done at 32, busy 11..31.
REQ-038 start pulsed at edge 15 mid-frame -> ignored, stream identical to REQ-037, single done.
REQ-039 wr_en to addr 3 (data 0xAA) at edge 14 during stream -> wr_err at 15, Dout of 4th pixel stays 0x03; next frame also 0x03.
REQ-040 wr_en addr 20 while idle -> wr_err pulse, no buffer change.
REQ-041 rst at edge 20 mid-frame -> data_valid=0, busy=0 from 21, no done; new start streams 0..19 again.
REQ-042 start at FIN edge then next edge -> first ignored, second gives full second frame with sof.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel pipeline: default frame geometry,
// buffer address width and the pixel-source FSM state encoding.
package sobel_pkg;

   localparam int SOBEL_N  = 450;   // frame height in rows
   localparam int SOBEL_M  = 600;   // frame width in columns
   localparam int SOBEL_AW = 19;    // raster address width, 2**AW >= N*M

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_FIN    = 2'd3
   } sobel_state_e;

   // Bits needed for a counter spanning 0..count-1 (never less than one).
   function automatic int cnt_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/sobel_frame_ram.sv
// Frame buffer: one write port, one registered read port, no reset so the
// array maps onto block RAM.
module sobel_frame_ram #(
   parameter int DEPTH = 270000,
   parameter int AW    = 19,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_r [DEPTH];

   // Write port: store one byte when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port: one cycle latency; a same-edge write is not forwarded.
   always_ff @(posedge clk) begin
      rdata <= mem_r[raddr];
   end

endmodule

// File: rtl/sobel_pixel_source.sv
// Streams one stored frame in raster order to the Sobel filter on request.
// The host loads the buffer while idle; once a frame starts the buffer is
// frozen and pixels leave back to back, one per clock, with no gaps.
module sobel_pixel_source
   import sobel_pkg::*;
#(
   parameter int N  = SOBEL_N,
   parameter int M  = SOBEL_M,
   parameter int AW = SOBEL_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          start,
   output logic          data_valid,
   output logic [7:0]    Dout,
   output logic          sof,
   output logic          eol,
   output logic          busy,
   output logic          done,
   output logic          wr_err
);

   localparam int            DEPTH    = N * M;
   localparam int            CW       = cnt_width(M);
   localparam int            RW       = cnt_width(N);
   localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
   localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

   sobel_state_e  state_r,   state_s;
   logic [AW-1:0] rd_addr_r, rd_addr_s;
   logic [CW-1:0] col_r,     col_s;
   logic [RW-1:0] row_r,     row_s;
   logic          valid_r,   valid_s;
   logic          sof_r,     sof_s;
   logic          eol_r,     eol_s;
   logic          busy_r,    busy_s;
   logic          done_r,    done_s;
   logic          wr_err_r,  wr_err_s;
   logic          wr_ok_s;
   logic          last_s;
   logic [7:0]    ram_q_s;

   sobel_frame_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (8)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok_s),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr_r),
      .rdata (ram_q_s)
   );

   // Write admission: writes land only while not busy and inside the frame.
   always_comb begin
      wr_ok_s  = 1'b0;
      wr_err_s = 1'b0;
      if (!rst && wr_en) begin
         if (busy_r || ({1'b0, wr_addr} >= DEPTH_X)) begin
            wr_err_s = 1'b1;
         end else begin
            wr_ok_s = 1'b1;
         end
      end else begin
         wr_ok_s  = 1'b0;
         wr_err_s = 1'b0;
      end
   end

   // Next state and next output values; counters describe the pixel on Dout.
   always_comb begin
      state_s   = state_r;
      rd_addr_s = rd_addr_r;
      col_s     = col_r;
      row_s     = row_r;
      valid_s   = 1'b0;
      sof_s     = 1'b0;
      eol_s     = 1'b0;
      busy_s    = busy_r;
      done_s    = 1'b0;
      last_s    = (row_r == ROW_LAST) && (col_r == COL_LAST);
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s   = ST_PRIME;
               busy_s    = 1'b1;
               rd_addr_s = {AW{1'b0}};
               col_s     = {CW{1'b0}};
               row_s     = {RW{1'b0}};
            end else begin
               busy_s = 1'b0;
            end
         end
         ST_PRIME: begin
            // Address 0 is read on this edge, so pixel 0 is valid next.
            state_s   = ST_STREAM;
            rd_addr_s = rd_addr_r + AW'(1);
            valid_s   = 1'b1;
            sof_s     = 1'b1;
            eol_s     = (COL_LAST == {CW{1'b0}});
            col_s     = {CW{1'b0}};
            row_s     = {RW{1'b0}};
         end
         ST_STREAM: begin
            if (last_s) begin
               state_s = ST_FIN;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               col_s   = {CW{1'b0}};
               row_s   = {RW{1'b0}};
            end else begin
               valid_s   = 1'b1;
               rd_addr_s = rd_addr_r + AW'(1);
               if (col_r == COL_LAST) begin
                  col_s = {CW{1'b0}};
                  row_s = row_r + RW'(1);
               end else begin
                  col_s = col_r + CW'(1);
                  row_s = row_r;
               end
               sof_s = (row_s == {RW{1'b0}}) && (col_s == {CW{1'b0}});
               eol_s = (col_s == COL_LAST);
            end
         end
         ST_FIN: begin
            // A start seen here is dropped; the next idle cycle may accept.
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears all but the buffer contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         rd_addr_r <= {AW{1'b0}};
         col_r     <= {CW{1'b0}};
         row_r     <= {RW{1'b0}};
         valid_r   <= 1'b0;
         sof_r     <= 1'b0;
         eol_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         wr_err_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         rd_addr_r <= rd_addr_s;
         col_r     <= col_s;
         row_r     <= row_s;
         valid_r   <= valid_s;
         sof_r     <= sof_s;
         eol_r     <= eol_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         wr_err_r  <= wr_err_s;
      end
   end

   assign data_valid = valid_r;
   assign sof        = sof_r;
   assign eol        = eol_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign wr_err     = wr_err_r;
   // The RAM output is only presented while a pixel is valid; zero otherwise.
   assign Dout       = valid_r ? ram_q_s : 8'd0;

endmodule

// File: tb/tb_sobel_pixel_source.sv
// Bench for sobel_pixel_source on a 4x5 frame. A schedule-based reference
// model predicts every output from the cycle on which a frame was accepted.
module tb_sobel_pixel_source;

   localparam int N  = 4;
   localparam int M  = 5;
   localparam int AW = 5;
   localparam int NM = N * M;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          start;
   logic          data_valid;
   logic [7:0]    Dout;
   logic          sof;
   logic          eol;
   logic          busy;
   logic          done;
   logic          wr_err;

   int         n_vec    = 0;
   int         n_mis    = 0;
   int         edge_no  = 0;
   bit         frame_on = 1'b0;
   int         s_edge   = 0;
   logic [7:0] mem_m [NM];
   logic [7:0] snap  [NM];

   always #5 clk = ~clk;

   sobel_pixel_source #(
      .N  (N),
      .M  (M),
      .AW (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .data_valid (data_valid),
      .Dout       (Dout),
      .sof        (sof),
      .eol        (eol),
      .busy       (busy),
      .done       (done),
      .wr_err     (wr_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input bit r, input bit st, input bit we, input int addr, input logic [7:0] dat);
      bit         busy_before;
      bit         e_valid, e_busy, e_done, e_sof, e_eol, e_werr;
      int         d;
      logic [7:0] e_dout;
      rst     = r;
      start   = st;
      wr_en   = we;
      wr_addr = addr[AW-1:0];
      wr_data = dat;
      @(posedge clk);
      edge_no++;
      // A frame occupies edges s..s+NM as busy (prime plus NM pixels).
      busy_before = frame_on && (edge_no - 1 - s_edge >= 0) && (edge_no - 1 - s_edge <= NM);
      e_werr = 1'b0;
      if (r) begin
         frame_on = 1'b0;
      end else begin
         e_werr = we && (busy_before || addr >= NM);
         if (we && !busy_before && addr < NM) mem_m[addr] = dat;
         // Accept unless a frame is still running, finishing or just finished.
         if (st && (!frame_on || edge_no - s_edge >= NM + 3)) begin
            frame_on = 1'b1;
            s_edge   = edge_no;
            snap     = mem_m;
         end
      end
      d       = edge_no - s_edge;
      e_valid = frame_on && d >= 1 && d <= NM;
      e_busy  = frame_on && d >= 0 && d <= NM;
      e_done  = frame_on && d == NM + 1;
      e_sof   = e_valid && d == 1;
      e_eol   = e_valid && ((d - 1) % M) == M - 1;
      e_dout  = 8'd0;
      if (e_valid) e_dout = snap[d - 1];
      @(negedge clk);
      check_eq("data_valid", data_valid, e_valid);
      check_eq("busy",       busy,       e_busy);
      check_eq("done",       done,       e_done);
      check_eq("sof",        sof,        e_sof);
      check_eq("eol",        eol,        e_eol);
      check_eq("wr_err",     wr_err,     e_werr);
      if (e_valid) check_eq("Dout", Dout, e_dout);
      if (r) check_eq("Dout_rst", Dout, 8'd0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 0, 8'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = {AW{1'b0}};
      wr_data = 8'd0;
      @(negedge clk);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 0, 8'd0);

      // Load buffer[a] = a, then stream one frame.
      for (int a = 0; a < NM; a++) cycle(1'b0, 1'b0, 1'b1, a, 8'(a));
      repeat (2) idle();
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (25) idle();

      // Mid-frame write to address 3 and mid-frame start are both rejected.
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      for (int i = 1; i <= 25; i++) begin
         if (i == 3)      cycle(1'b0, 1'b0, 1'b1, 3, 8'hAA);
         else if (i == 5) cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
         else             idle();
      end
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (25) idle();

      // Out-of-range writes while idle.
      cycle(1'b0, 1'b0, 1'b1, 20, 8'h55);
      cycle(1'b0, 1'b0, 1'b1, 31, 8'h66);
      idle();

      // Write in the same cycle as the accepted start is seen by that frame.
      cycle(1'b0, 1'b1, 1'b1, 0, 8'h80);
      repeat (25) idle();

      // Reset mid-frame, then a fresh frame.
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (9) idle();
      cycle(1'b1, 1'b0, 1'b0, 0, 8'd0);
      repeat (3) idle();
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (25) idle();

      // Back to back: start on the finishing cycle, then on the next one.
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (21) idle();
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      cycle(1'b0, 1'b1, 1'b0, 0, 8'd0);
      repeat (25) idle();

      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 99) < 1,
               $urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 30,
               $urandom_range(0, 31),
               8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
